move_btn_conditioner: RTL and testbench



---
 rtl/move_btn_conditioner.sv | 129 ++++++++++++
 tb/tb_move_btn_conditioner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/move_btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce, one pulse per press with optional
// auto-repeat, and a post-collision lockout that also waits for the button to be released.
module move_btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 3125000,
    parameter int unsigned LOCKOUT_CYCLES  = 25000000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic collision,
    output logic move_pulse,
    output logic btn_level,
    output logic locked
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DW-1:0]    DcntLast   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHeld, StRepeat, StLockout} state_e;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    state_e           state_q, state_d;
    logic             pulse_q, pulse_d;
    logic             press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            dcnt_q       <= '0;
            timer_q      <= '0;
            state_q      <= StIdle;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            dcnt_q       <= dcnt_d;
            timer_q      <= timer_d;
            state_q      <= state_d;
            pulse_q      <= pulse_d;
        end
    end

    // Level only changes after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        level_d = level_q;
        dcnt_d  = '0;
        if (sync2_q != level_q) begin
            if (dcnt_q == DcntLast) begin
                level_d = sync2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    assign press = level_q & ~level_prev_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        pulse_d = 1'b0;
        if (collision) begin
            // Collision wins over any same-cycle press or repeat.
            state_d = StLockout;
            timer_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    timer_d = '0;
                    if (press) begin
                        pulse_d = 1'b1;
                        state_d = StHeld;
                    end
                end
                StHeld: begin
                    if (!level_q) begin
                        state_d = StIdle;
                        timer_d = '0;
                    end else if (REPEAT_EN && (timer_q == DelayLast)) begin
                        pulse_d = 1'b1;
                        state_d = StRepeat;
                        timer_d = '0;
                    end
                end
                StRepeat: begin
                    if (!level_q) begin
                        state_d = StIdle;
                        timer_d = '0;
                    end else if (timer_q == PeriodLast) begin
                        pulse_d = 1'b1;
                        timer_d = '0;
                    end
                end
                StLockout: begin
                    if (timer_q == LockLast) begin
                        timer_d = timer_q;
                        // Button must also be released so a held press cannot replay instantly.
                        if (!level_q) begin
                            state_d = StIdle;
                            timer_d = '0;
                        end
                    end
                end
            endcase
        end
    end

    assign move_pulse = pulse_q;
    assign btn_level  = level_q;
    assign locked     = (state_q == StLockout);

endmodule

// File: tb/tb_move_btn_conditioner.sv
// Directed bench for move_btn_conditioner: one repeat-enabled and one repeat-disabled instance
// driven in parallel, checked every clock against hand-built per-edge expectation vectors.
module tb_move_btn_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_raw = 1'b0;
    logic collision = 1'b0;
    logic pulse0, level0, locked0;
    logic pulse1, level1, locked1;

    int n_checks = 0;
    int n_errors = 0;

    // Bit e of each vector = value at / sampled by clock edge e after the test starts.
    logic [255:0] raw_v, col_v, p0_v, p1_v, lv_v, lk_v;

    localparam int SelRaw = 0;
    localparam int SelCol = 1;
    localparam int SelP0  = 2;
    localparam int SelP1  = 3;
    localparam int SelLv  = 4;
    localparam int SelLk  = 5;

    always #5 clk = ~clk;

    move_btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN      (1'b1),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .LOCKOUT_CYCLES (30),
        .CNT_W          (8)
    ) u_dut_rep (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .collision (collision),
        .move_pulse(pulse0),
        .btn_level (level0),
        .locked    (locked0)
    );

    move_btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN      (1'b0),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .LOCKOUT_CYCLES (30),
        .CNT_W          (8)
    ) u_dut_norep (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .collision (collision),
        .move_pulse(pulse1),
        .btn_level (level1),
        .locked    (locked1)
    );

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, " pulse0"}, pulse0, 1'b0);
        check_eq({tag, " level0"}, level0, 1'b0);
        check_eq({tag, " locked0"}, locked0, 1'b0);
        check_eq({tag, " pulse1"}, pulse1, 1'b0);
        check_eq({tag, " level1"}, level1, 1'b0);
        check_eq({tag, " locked1"}, locked1, 1'b0);
    endtask

    task automatic clear_vecs();
        raw_v = '0;
        col_v = '0;
        p0_v  = '0;
        p1_v  = '0;
        lv_v  = '0;
        lk_v  = '0;
    endtask

    task automatic mark(input int sel, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            case (sel)
                SelRaw:  raw_v[i] = 1'b1;
                SelCol:  col_v[i] = 1'b1;
                SelP0:   p0_v[i]  = 1'b1;
                SelP1:   p1_v[i]  = 1'b1;
                SelLv:   lv_v[i]  = 1'b1;
                SelLk:   lk_v[i]  = 1'b1;
                default: ;
            endcase
        end
    endtask

    // Leaves reset released between edges, so the next posedge is edge 1.
    task automatic do_reset(input string tag);
        btn_raw   = 1'b0;
        collision = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #2;
        check_zero(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run(input string tag, input int n);
        btn_raw   = raw_v[1];
        collision = col_v[1];
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("%s e%0d pulse0", tag, e), pulse0, p0_v[e]);
            check_eq($sformatf("%s e%0d pulse1", tag, e), pulse1, p1_v[e]);
            check_eq($sformatf("%s e%0d level", tag, e), level0, lv_v[e]);
            check_eq($sformatf("%s e%0d level1", tag, e), level1, lv_v[e]);
            check_eq($sformatf("%s e%0d locked", tag, e), locked0, lk_v[e]);
            check_eq($sformatf("%s e%0d locked1", tag, e), locked1, lk_v[e]);
            btn_raw   = raw_v[e+1];
            collision = col_v[e+1];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Clean press: level rises at edge 6, single pulse at edge 7.
        do_reset("rst_clean");
        clear_vecs();
        mark(SelRaw, 1, 10);
        mark(SelLv, 6, 15);
        mark(SelP0, 7, 7);
        mark(SelP1, 7, 7);
        run("clean", 25);

        // Bounce 3 high / 1 low never survives the debounce.
        do_reset("rst_bounce");
        clear_vecs();
        for (int e = 1; e <= 20; e++) begin
            if (((e - 1) % 4) != 3) raw_v[e] = 1'b1;
        end
        run("bounce", 30);

        // Auto-repeat on the enabled instance only.
        do_reset("rst_repeat");
        clear_vecs();
        mark(SelRaw, 1, 60);
        mark(SelLv, 6, 65);
        mark(SelP0, 7, 7);
        mark(SelP0, 27, 27);
        mark(SelP0, 35, 35);
        mark(SelP0, 43, 43);
        mark(SelP0, 51, 51);
        mark(SelP0, 59, 59);
        mark(SelP1, 7, 7);
        run("repeat", 75);

        // Collision while held; lockout exits after timer saturates and release, then new press.
        do_reset("rst_lock");
        clear_vecs();
        mark(SelRaw, 1, 80);
        mark(SelCol, 16, 16);
        mark(SelLv, 6, 85);
        mark(SelLk, 16, 86);
        mark(SelP0, 7, 7);
        mark(SelP1, 7, 7);
        mark(SelRaw, 91, 100);
        mark(SelLv, 96, 105);
        mark(SelP0, 97, 97);
        mark(SelP1, 97, 97);
        run("lockout", 110);

        // Collision coincides with the would-be first pulse, then retriggers at timer 25.
        do_reset("rst_retrig");
        clear_vecs();
        mark(SelRaw, 1, 10);
        mark(SelCol, 7, 7);
        mark(SelCol, 33, 33);
        mark(SelLv, 6, 15);
        mark(SelLk, 7, 62);
        run("retrig", 70);

        // Async reset while a repeat pulse is high, button held through reset.
        do_reset("rst_async");
        clear_vecs();
        mark(SelRaw, 1, 120);
        mark(SelLv, 6, 35);
        mark(SelP0, 7, 7);
        mark(SelP0, 27, 27);
        mark(SelP0, 35, 35);
        mark(SelP1, 7, 7);
        run("pre_rst", 35);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #2;
        reset = 1'b0;
        clear_vecs();
        mark(SelRaw, 1, 20);
        mark(SelLv, 6, 25);
        mark(SelP0, 7, 7);
        mark(SelP1, 7, 7);
        run("post_rst", 30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
